// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick-driven countdown timer.
//   state_t : FSM encoding (IDLE, RUN, HOLD, EXPIRED)
package tick_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_EXP  = 2'd3
    } state_t;

endpackage

// File: rtl/tick_timer.sv
// Programmable countdown timer that counts tick_en pulses rather than clock
// edges. Expiry raises a one-cycle done pulse and sets a sticky irq.
// Supports one-shot and auto-reload modes, plus pause (stop) and resume (start).
// Ports:
//   sys_clk, sys_rst         : clock, synchronous active-high reset
//   tick_en                  : count enable, one sys_clk wide (may be held high)
//   load, load_val           : capture a new reload/count value
//   start, stop              : begin/resume and pause pulses
//   auto_reload              : 1 = periodic, 0 = one-shot (sampled at expiry)
//   irq_clr                  : clear the sticky irq
//   cnt_val, running, done, irq : registered status outputs
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             tick_en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic             irq_clr,
    output logic [CNT_W-1:0] cnt_val,
    output logic             running,
    output logic             done,
    output logic             irq
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] reload_reg, reload_nxt, cnt_nxt;
    logic             expire;

    // One priority chain: load > stop > start > tick_en. A start while already
    // running does nothing, so it falls through and the tick still counts.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt_val;
        reload_nxt = reload_reg;
        expire     = 1'b0;
        if (load) begin
            reload_nxt = load_val;
            cnt_nxt    = load_val;
            state_nxt  = (start && load_val != '0) ? ST_RUN : ST_IDLE;
        end else if (stop) begin
            if (state == ST_RUN) state_nxt = ST_HOLD;
        end else if (start && state != ST_RUN) begin
            unique case (state)
                ST_EXP: begin
                    // Restart from the reload value; the counter sits at 0 here.
                    if (reload_reg != '0) begin
                        cnt_nxt   = reload_reg;
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    if (cnt_val != '0) state_nxt = ST_RUN;
                end
            endcase
        end else if (state == ST_RUN && tick_en) begin
            if (cnt_val > CNT_W'(1)) begin
                cnt_nxt = cnt_val - CNT_W'(1);
            end else if (cnt_val == CNT_W'(1)) begin
                expire = 1'b1;
                if (auto_reload) begin
                    cnt_nxt = reload_reg;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = ST_EXP;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            cnt_val    <= '0;
            reload_reg <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
            irq        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt_val    <= cnt_nxt;
            reload_reg <= reload_nxt;
            running    <= (state_nxt == ST_RUN);
            done       <= expire;
            // A new expiry beats a simultaneous clear.
            irq        <= expire | (irq & ~irq_clr);
        end
    end

endmodule
